pulse_capture: RTL and testbench
================================

Name: pulse_capture

Overview:
- Receive-side counterpart to the debug pulse stretcher.
- Takes a stretched or asynchronous pulse and synchronises it.
- Rejects glitches shorter than MIN_WIDTH.
- Emits a single-cycle strobe for each qualified pulse and reports each pulse's high-time in clock cycles over a valid/ready handshake.
- Sits between external debug/control lines and the internal logic or logging path in the beebthru FPGA.

Parameters:
- MIN_WIDTH, 3, minimum synchronised high-time in cycles for a pulse to qualify; legal range 2..255.
- WIDTH_BITS, 16, width of the measurement counter and result bus.

Ports:
- clk  input  1  system clock; all logic on posedge.
- nReset  input  1  asynchronous, active-low reset.
- in_pulse  input  1  asynchronous pulse input.
- out_strobe  output  1  one-cycle strobe per qualified pulse.
- width_data  output  WIDTH_BITS  measured high-time of the last qualified pulse.
- width_sat  output  1  width_data saturated; qualifies width_data.
- width_overrun  output  1  an unread result was overwritten; qualifies width_data.
- width_valid  output  1  result available.
- width_ready  input  1  consumer accepts the result.
- glitch_count  output  8  saturating count of rejected pulses.

Behaviour:
- Reset:
  - Asynchronous, active-low. All state and outputs clear to 0: FSM goes to IDLE, armed=0, and synchroniser flops clear.
- Synchroniser:
  - 2-flop synchroniser gives in_s. in_s lags in_pulse by 2 clk.
- Arming:
  - After reset, armed=0 until in_s is sampled 0; armed then stays 1.
  - While armed=0 the FSM stays in IDLE, so a pulse already high at reset release is ignored entirely.
- FSM states: IDLE, QUALIFY, HIGH.
  - IDLE: if armed && in_s=1, go to QUALIFY with cnt<=1.
  - QUALIFY, in_s=1: cnt<=cnt+1. If cnt+1==MIN_WIDTH, go to HIGH and assert out_strobe on the next cycle for exactly 1 cycle.
  - QUALIFY, in_s=0: go to IDLE, glitch_count<=glitch_count+1, saturating at 255. No strobe, no result.
  - HIGH, in_s=1: cnt saturating increment. If cnt is already all-ones it holds and sat<=1.
  - HIGH, in_s=0: go to IDLE. Load width_data<=cnt and width_sat<=sat, set width_valid<=1, then clear cnt and sat.
- Strobe latency: out_strobe rises MIN_WIDTH+3 cycles after the first clk edge that samples in_pulse=1.
  - 2 cycles are synchroniser.
  - The remaining cycles are qualification plus the register stage.
- Width measurement: width_data equals the number of cycles in_s was high. For a clean synchronous input this equals the in_pulse high cycles.
- Result timing: width_valid rises 1 cycle after the HIGH→IDLE transition.
- Handshake:
  - A transfer occurs on a cycle with width_valid && width_ready.
  - width_data, width_sat and width_overrun stay stable while width_valid=1 and no transfer occurs.
  - On a transfer with no new load: width_valid<=0 and width_overrun<=0.
  - New load while width_valid=1 and no transfer: overwrite data, width_overrun<=1.
  - New load on the same cycle as a transfer: new data, width_valid stays 1, width_overrun<=0.
- Back-to-back pulses: IDLE may re-enter QUALIFY on the cycle immediately after the HIGH→IDLE transition. Minimum accepted low gap is 1 synchronised cycle.
- glitch_count never wraps and clears only on reset.

Optional Feature:
- Macro: PULSE_CAPTURE_MAXHOLD_EN.
- Defined:
  - Adds output max_width [WIDTH_BITS].
  - On every result load, max_width<=max(max_width, new width), comparing unsigned saturated values.
  - Adds input max_clear. max_clear=1 sets max_width<=0 next cycle; a load on the same cycle is ignored for max.
  - max_width resets to 0.
- Not defined: neither port exists and no max logic is generated.

Test Plan:
- Reset release with in_pulse held 1 for 20 cycles, then 0, then a 5-cycle pulse → no strobe for the first pulse; exactly one strobe; width_data=5; glitch_count=0.
- in_pulse high 2 cycles (MIN_WIDTH=3) ×3, then high 10 cycles → glitch_count=3; one strobe, 6 cycles after the first sampled high edge; width_data=10, width_valid=1.
- width_ready=0, two pulses of 7 then 12 cycles → width_data=12, width_overrun=1; then width_ready=1 for one cycle → width_valid=0, width_overrun=0.
- WIDTH_BITS=4, 20-cycle pulse → width_data=15, width_sat=1.
- Pulse of 4 ending on the same cycle the previous result is accepted → width_valid stays 1, width_data=4, width_overrun=0.
- nReset asserted mid-HIGH on a 50-cycle pulse → all outputs 0 immediately; no result until in_pulse goes low and a fresh pulse arrives.

Source files
------------

// File: rtl/pulse_capture_if.sv
// Result channel of pulse_capture: measured width plus qualifiers over valid/ready.
interface pulse_capture_if #(
    parameter int unsigned WIDTH_BITS = 16
) ();
    logic [WIDTH_BITS-1:0] width_data;
    logic                  width_sat;
    logic                  width_overrun;
    logic                  width_valid;
    logic                  width_ready;

    modport master (
        output width_data,
        output width_sat,
        output width_overrun,
        output width_valid,
        input  width_ready
    );

    modport slave (
        input  width_data,
        input  width_sat,
        input  width_overrun,
        input  width_valid,
        output width_ready
    );
endinterface

// File: rtl/pulse_capture.sv
// Synchronises an async pulse, rejects glitches, strobes and measures qualified pulses.
// Define PULSE_CAPTURE_MAXHOLD_EN to add the max_width tracker (max_clear / max_width ports).
module pulse_capture #(
    parameter int unsigned MIN_WIDTH  = 3,
    parameter int unsigned WIDTH_BITS = 16
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  in_pulse,
    output logic                  out_strobe,
    output logic [7:0]            glitch_count,
`ifdef PULSE_CAPTURE_MAXHOLD_EN
    input  logic                  max_clear,
    output logic [WIDTH_BITS-1:0] max_width,
`endif
    pulse_capture_if.master       res
);
    localparam int unsigned       CNT_W   = WIDTH_BITS + 1;
    localparam logic [CNT_W-1:0]  MIN_CNT = CNT_W'(MIN_WIDTH);

    typedef enum logic [1:0] {IDLE, QUALIFY, HIGH} state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [1:0]            fill_q, fill_d;
    logic                  armed_q, armed_d;
    logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
    logic                  sat_q, sat_d;
    logic [1:0]            stb_pipe_q, stb_pipe_d;
    logic                  out_strobe_q, out_strobe_d;
    logic [7:0]            glitch_q, glitch_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [WIDTH_BITS-1:0] pend_data_q, pend_data_d;
    logic                  pend_sat_q, pend_sat_d;
    logic [WIDTH_BITS-1:0] res_data_q, res_data_d;
    logic                  res_sat_q, res_sat_d;
    logic                  res_ovr_q, res_ovr_d;
    logic                  res_vld_q, res_vld_d;
    logic                  in_s;
    logic                  xfer;
    logic [CNT_W-1:0]      cnt_inc;

    assign in_s = sync2_q;

    // Synchroniser, arming and pulse FSM
    always_comb begin
        sync1_d      = in_pulse;
        sync2_d      = sync1_q;
        fill_d       = {fill_q[0], 1'b1};
        // in_s is only trusted once both synchroniser flops hold real samples
        armed_d      = armed_q | (fill_q[1] & ~in_s);
        state_d      = state_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        glitch_d     = glitch_q;
        // strobe is delayed so it lands MIN_WIDTH+3 edges after the pin is first sampled high
        stb_pipe_d   = {stb_pipe_q[0], 1'b0};
        out_strobe_d = stb_pipe_q[1];
        pend_vld_d   = 1'b0;
        pend_data_d  = pend_data_q;
        pend_sat_d   = pend_sat_q;
        cnt_inc      = {1'b0, cnt_q} + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (armed_q && in_s) begin
                    state_d = QUALIFY;
                    cnt_d   = WIDTH_BITS'(1);
                end
            end
            QUALIFY: begin
                if (in_s) begin
                    cnt_d = cnt_inc[WIDTH_BITS-1:0];
                    if (cnt_inc == MIN_CNT) begin
                        state_d       = HIGH;
                        stb_pipe_d[0] = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (glitch_q != 8'hFF) begin
                        glitch_d = glitch_q + 8'd1;
                    end
                end
            end
            HIGH: begin
                if (in_s) begin
                    if (&cnt_q) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[WIDTH_BITS-1:0];
                    end
                end else begin
                    state_d     = IDLE;
                    pend_vld_d  = 1'b1;
                    pend_data_d = cnt_q;
                    pend_sat_d  = sat_q;
                    cnt_d       = '0;
                    sat_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result register and valid/ready handshake
    always_comb begin
        xfer       = res_vld_q & res.width_ready;
        res_data_d = res_data_q;
        res_sat_d  = res_sat_q;
        res_ovr_d  = res_ovr_q;
        res_vld_d  = res_vld_q;
        if (pend_vld_q) begin
            res_data_d = pend_data_q;
            res_sat_d  = pend_sat_q;
            res_vld_d  = 1'b1;
            res_ovr_d  = res_vld_q & ~xfer;
        end else if (xfer) begin
            res_vld_d  = 1'b0;
            res_ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            fill_q       <= 2'b00;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            stb_pipe_q   <= 2'b00;
            out_strobe_q <= 1'b0;
            glitch_q     <= 8'd0;
            pend_vld_q   <= 1'b0;
            pend_data_q  <= '0;
            pend_sat_q   <= 1'b0;
            res_data_q   <= '0;
            res_sat_q    <= 1'b0;
            res_ovr_q    <= 1'b0;
            res_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            stb_pipe_q   <= stb_pipe_d;
            out_strobe_q <= out_strobe_d;
            glitch_q     <= glitch_d;
            pend_vld_q   <= pend_vld_d;
            pend_data_q  <= pend_data_d;
            pend_sat_q   <= pend_sat_d;
            res_data_q   <= res_data_d;
            res_sat_q    <= res_sat_d;
            res_ovr_q    <= res_ovr_d;
            res_vld_q    <= res_vld_d;
        end
    end

`ifdef PULSE_CAPTURE_MAXHOLD_EN
    logic [WIDTH_BITS-1:0] max_q, max_d;

    // Running maximum of loaded results; clear wins over a same-cycle load
    always_comb begin
        max_d = max_q;
        if (max_clear) begin
            max_d = '0;
        end else if (pend_vld_q && (pend_data_q > max_q)) begin
            max_d = pend_data_q;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_width = max_q;
`endif

    assign out_strobe        = out_strobe_q;
    assign glitch_count      = glitch_q;
    assign res.width_data    = res_data_q;
    assign res.width_sat     = res_sat_q;
    assign res.width_overrun = res_ovr_q;
    assign res.width_valid   = res_vld_q;
endmodule

// File: tb/tb_pulse_capture.sv
// Scoreboard bench for pulse_capture: a 16-bit instance and a 4-bit instance for saturation.
module tb_pulse_capture;
    logic       clk = 1'b0;
    logic       nReset;
    logic       in_pulse;
    logic       in_pulse2;
    logic       out_strobe;
    logic       out_strobe2;
    logic [7:0] glitch_count;
    logic [7:0] glitch_count2;
`ifdef PULSE_CAPTURE_MAXHOLD_EN
    logic [15:0] maxw;
    logic [3:0]  maxw2;
`endif

    pulse_capture_if #(.WIDTH_BITS(16)) dif ();
    pulse_capture_if #(.WIDTH_BITS(4))  dif2 ();

    always #5 clk = ~clk;

    pulse_capture #(.MIN_WIDTH(3), .WIDTH_BITS(16)) dut (
        .clk          (clk),
        .nReset       (nReset),
        .in_pulse     (in_pulse),
        .out_strobe   (out_strobe),
        .glitch_count (glitch_count),
`ifdef PULSE_CAPTURE_MAXHOLD_EN
        .max_clear    (1'b0),
        .max_width    (maxw),
`endif
        .res          (dif)
    );

    pulse_capture #(.MIN_WIDTH(3), .WIDTH_BITS(4)) dut2 (
        .clk          (clk),
        .nReset       (nReset),
        .in_pulse     (in_pulse2),
        .out_strobe   (out_strobe2),
        .glitch_count (glitch_count2),
`ifdef PULSE_CAPTURE_MAXHOLD_EN
        .max_clear    (1'b0),
        .max_width    (maxw2),
`endif
        .res          (dif2)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
        logic        ovr;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;
    int   total    = 0;
    int   bad      = 0;
    int   strobes1 = 0;
    int   strobes2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic expect1(input logic [15:0] d, input logic s, input logic o);
        exp_t e;
        e.data = d;
        e.sat  = s;
        e.ovr  = o;
        q1.push_back(e);
    endtask

    task automatic expect2(input logic [15:0] d, input logic s, input logic o);
        exp_t e;
        e.data = d;
        e.sat  = s;
        e.ovr  = o;
        q2.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: counts strobes and checks every accepted result against the queue head
    always @(negedge clk) begin
        if (nReset === 1'b1) begin
            if (out_strobe === 1'b1) strobes1++;
            if (out_strobe2 === 1'b1) strobes2++;
            if (dif.width_valid && dif.width_ready) begin
                chk("dut1 result expected", 32'(q1.size() > 0), 32'd1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("dut1 width_data", 32'(dif.width_data), 32'(e1.data));
                    chk("dut1 width_sat", 32'(dif.width_sat), 32'(e1.sat));
                    chk("dut1 width_overrun", 32'(dif.width_overrun), 32'(e1.ovr));
                end
            end
            if (dif2.width_valid && dif2.width_ready) begin
                chk("dut2 result expected", 32'(q2.size() > 0), 32'd1);
                if (q2.size() > 0) begin
                    e2 = q2.pop_front();
                    chk("dut2 width_data", 32'(dif2.width_data), 32'(e2.data));
                    chk("dut2 width_sat", 32'(dif2.width_sat), 32'(e2.sat));
                    chk("dut2 width_overrun", 32'(dif2.width_overrun), 32'(e2.ovr));
                end
            end
        end
    end

    initial begin
        int lat;
        int base;
        nReset           = 1'b0;
        in_pulse         = 1'b1;
        in_pulse2        = 1'b0;
        dif.width_ready  = 1'b1;
        dif2.width_ready = 1'b1;
        tick(3);
        chk("reset out_strobe", 32'(out_strobe), 32'd0);
        chk("reset width_valid", 32'(dif.width_valid), 32'd0);
        chk("reset width_data", 32'(dif.width_data), 32'd0);
        chk("reset glitch_count", 32'(glitch_count), 32'd0);

        // Pulse held high through reset release is ignored; the next 5-cycle pulse is measured
        nReset = 1'b1;
        tick(20);
        in_pulse = 1'b0;
        tick(5);
        expect1(16'd5, 1'b0, 1'b0);
        in_pulse = 1'b1;
        tick(5);
        in_pulse = 1'b0;
        tick(12);
        chk("t1 strobes", 32'(strobes1), 32'd1);
        chk("t1 glitch_count", 32'(glitch_count), 32'd0);
        chk("t1 results drained", 32'(q1.size()), 32'd0);

        // Three 2-cycle glitches, then a 10-cycle pulse with strobe latency measured
        dif.width_ready = 1'b0;
        repeat (3) begin
            in_pulse = 1'b1;
            tick(2);
            in_pulse = 1'b0;
            tick(4);
        end
        chk("t2 glitch_count", 32'(glitch_count), 32'd3);
        expect1(16'd10, 1'b0, 1'b0);
        base     = strobes1;
        lat      = -1;
        in_pulse = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) in_pulse = 1'b0;
            if (out_strobe === 1'b1 && lat < 0) lat = k;
        end
        chk("t2 strobe latency", 32'(lat), 32'd6);
        chk("t2 strobe count", 32'(strobes1 - base), 32'd1);
        chk("t2 width_valid", 32'(dif.width_valid), 32'd1);
        chk("t2 width_data", 32'(dif.width_data), 32'd10);
        dif.width_ready = 1'b1;
        tick(1);
        dif.width_ready = 1'b0;
        chk("t2 valid after accept", 32'(dif.width_valid), 32'd0);

        // Unread 7-cycle result overwritten by a 12-cycle result
        in_pulse = 1'b1;
        tick(7);
        in_pulse = 1'b0;
        tick(6);
        expect1(16'd12, 1'b0, 1'b1);
        in_pulse = 1'b1;
        tick(12);
        in_pulse = 1'b0;
        tick(8);
        chk("t3 width_data", 32'(dif.width_data), 32'd12);
        chk("t3 width_overrun", 32'(dif.width_overrun), 32'd1);
        dif.width_ready = 1'b1;
        tick(1);
        dif.width_ready = 1'b0;
        chk("t3 valid after accept", 32'(dif.width_valid), 32'd0);
        chk("t3 overrun after accept", 32'(dif.width_overrun), 32'd0);

        // New 4-cycle result loads on the same edge the pending 6-cycle result is accepted
        expect1(16'd6, 1'b0, 1'b0);
        in_pulse = 1'b1;
        tick(6);
        in_pulse = 1'b0;
        tick(10);
        expect1(16'd4, 1'b0, 1'b0);
        in_pulse = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) in_pulse = 1'b0;
            if (k == 6) dif.width_ready = 1'b1;
            if (k == 7) dif.width_ready = 1'b0;
        end
        chk("t5 width_valid", 32'(dif.width_valid), 32'd1);
        chk("t5 width_data", 32'(dif.width_data), 32'd4);
        chk("t5 width_overrun", 32'(dif.width_overrun), 32'd0);
        dif.width_ready = 1'b1;
        tick(1);
        chk("t5 valid after accept", 32'(dif.width_valid), 32'd0);

        // 4-bit instance: 20-cycle pulse saturates at 15
        expect2(16'd15, 1'b1, 1'b0);
        in_pulse2 = 1'b1;
        tick(20);
        in_pulse2 = 1'b0;
        tick(10);
        chk("t4 strobes", 32'(strobes2), 32'd1);
        chk("t4 results drained", 32'(q2.size()), 32'd0);

        // Reset in the middle of a 50-cycle pulse
        base     = strobes1;
        in_pulse = 1'b1;
        tick(20);
        nReset = 1'b0;
        #1;
        chk("t6 out_strobe", 32'(out_strobe), 32'd0);
        chk("t6 width_valid", 32'(dif.width_valid), 32'd0);
        chk("t6 width_data", 32'(dif.width_data), 32'd0);
        chk("t6 width_sat", 32'(dif.width_sat), 32'd0);
        chk("t6 width_overrun", 32'(dif.width_overrun), 32'd0);
        chk("t6 glitch_count", 32'(glitch_count), 32'd0);
        tick(2);
        nReset = 1'b1;
        tick(28);
        in_pulse = 1'b0;
        tick(10);
        chk("t6 no strobe after reset", 32'(strobes1 - base), 32'd1);
        chk("t6 no result after reset", 32'(dif.width_valid), 32'd0);
        expect1(16'd5, 1'b0, 1'b0);
        in_pulse = 1'b1;
        tick(5);
        in_pulse = 1'b0;
        tick(12);
        chk("t6 fresh pulse strobe", 32'(strobes1 - base), 32'd2);
        chk("final dut1 queue empty", 32'(q1.size()), 32'd0);
        chk("final dut2 queue empty", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
